// File: rtl/input_conditioner_pkg.sv
// ============================================================================
// Module   : input_conditioner_pkg
// Shared game-state, arrow-format and FSM encodings for the input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_conditioner_pkg;

  localparam int STATE_BITS      = 2;
  localparam int NUM_ARROWS_BITS = 3;

  localparam logic [STATE_BITS:0] STATE_PLAY = 3'd2;

  localparam int ARROW_U = 3;
  localparam int ARROW_D = 2;
  localparam int ARROW_L = 1;
  localparam int ARROW_R = 0;

  localparam logic [1:0] c_FSM_IDLE   = 2'd0;
  localparam logic [1:0] c_FSM_GATHER = 2'd1;
  localparam logic [1:0] c_FSM_PEND   = 2'd2;

  // A counter for a terminal value of 0 still needs one bit to exist.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_conditioner_debouncer.sv
// ============================================================================
// Module   : debouncer
// Input register(s), stability counter and stable level for one push-button.
// Macro    : INPUT_COND_SYNC_EN selects a two-flop synchronizer input stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] c_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          w_sample;
  logic          w_differs;
  logic          w_terminal;
  logic          r_level;
  logic [CW-1:0] r_cnt;

`ifdef INPUT_COND_SYNC_EN
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  assign w_sample = r_sync;
`else
  logic r_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample <= 1'b0;
    end else begin
      r_sample <= i_btn;
    end
  end

  assign w_sample = r_sample;
`endif

  assign w_differs  = (w_sample != r_level);
  assign w_terminal = w_differs && (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (!w_differs) begin
      r_cnt <= '0;
    end else if (w_terminal) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The rise pulse coincides with the edge on which the level flips to 1.
  assign o_level = r_level;
  assign o_rise  = w_terminal && !r_level;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module   : input_conditioner
// Debounces the arrow buttons, merges near-simultaneous presses into chords
// and offers each chord over valid/ready.
// Macro    : INPUT_COND_SYNC_EN adds a two-flop synchronizer per button.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHORD_CYCLES    = 2000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btnU,
  input  logic                       btnD,
  input  logic                       btnL,
  input  logic                       btnR,
  input  logic [STATE_BITS:0]        state,
  output logic                       press_valid,
  output logic [NUM_ARROWS_BITS:0]   press_arrow,
  input  logic                       press_ready,
  output logic [NUM_ARROWS_BITS:0]   held,
  output logic                       overrun
);

  localparam int CW = cntWidth(CHORD_CYCLES);
  localparam logic [CW-1:0] c_CHORD_LAST = CW'(CHORD_CYCLES - 1);

  logic [NUM_ARROWS_BITS:0] w_raw;
  logic [NUM_ARROWS_BITS:0] w_rise;
  logic                     w_inPlay;
  logic                     w_accept;

  logic [1:0]               r_fsm;
  logic [NUM_ARROWS_BITS:0] r_mask;
  logic [CW-1:0]            r_cnt;
  logic                     r_overrun;

  logic [1:0]               w_nextFsm;
  logic [NUM_ARROWS_BITS:0] w_nextMask;
  logic [CW-1:0]            w_nextCnt;
  logic                     w_nextOverrun;

  assign w_raw[ARROW_U] = btnU;
  assign w_raw[ARROW_D] = btnD;
  assign w_raw[ARROW_L] = btnL;
  assign w_raw[ARROW_R] = btnR;

  generate
    for (genvar i = 0; i <= NUM_ARROWS_BITS; i++) begin : g_btn
      debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (w_raw[i]),
        .o_level (held[i]),
        .o_rise  (w_rise[i])
      );
    end
  endgenerate

  assign w_inPlay = (state == STATE_PLAY);
  assign w_accept = (r_fsm == c_FSM_PEND) && press_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm     <= c_FSM_IDLE;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_fsm     <= w_nextFsm;
      r_mask    <= w_nextMask;
      r_cnt     <= w_nextCnt;
      r_overrun <= w_nextOverrun;
    end
  end

  always_comb begin
    w_nextFsm     = r_fsm;
    w_nextMask    = r_mask;
    w_nextCnt     = r_cnt;
    w_nextOverrun = r_overrun;
    if (!w_inPlay) begin
      w_nextFsm     = c_FSM_IDLE;
      w_nextMask    = '0;
      w_nextCnt     = '0;
      w_nextOverrun = 1'b0;
    end else begin
      case (r_fsm)
        c_FSM_IDLE: begin
          if (|w_rise) begin
            w_nextFsm  = c_FSM_GATHER;
            w_nextMask = w_rise;
            w_nextCnt  = c_CHORD_LAST;
          end
        end
        c_FSM_GATHER: begin
          w_nextMask = r_mask | w_rise;
          if (r_cnt == '0) begin
            w_nextFsm = c_FSM_PEND;
          end else begin
            w_nextCnt = r_cnt - 1'b1;
          end
        end
        c_FSM_PEND: begin
          // A press landing on the accept cycle opens the next chord instead of being lost.
          if (w_accept) begin
            if (|w_rise) begin
              w_nextFsm  = c_FSM_GATHER;
              w_nextMask = w_rise;
              w_nextCnt  = c_CHORD_LAST;
            end else begin
              w_nextFsm  = c_FSM_IDLE;
              w_nextMask = '0;
            end
          end else if (|w_rise) begin
            w_nextOverrun = 1'b1;
          end
        end
        default: begin
          w_nextFsm  = c_FSM_IDLE;
          w_nextMask = '0;
          w_nextCnt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    press_valid = 1'b0;
    press_arrow = '0;
    if (r_fsm == c_FSM_PEND) begin
      press_valid = 1'b1;
      press_arrow = r_mask;
    end
  end

  assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================================
// Module   : tb_input_conditioner
// Self-checking bench for input_conditioner with short debounce/chord windows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int DEB   = 4;
  localparam int CHORD = 3;
`ifdef INPUT_COND_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 1;
`endif
  localparam int HE  = DLY - 1 + DEB;
  localparam int LAT = HE + CHORD;
  localparam logic [STATE_BITS:0] NOPLAY = STATE_PLAY ^ {{STATE_BITS{1'b0}}, 1'b1};

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     btnU, btnD, btnL, btnR;
  logic [STATE_BITS:0]      state;
  logic                     press_valid;
  logic [NUM_ARROWS_BITS:0] press_arrow;
  logic                     press_ready;
  logic [NUM_ARROWS_BITS:0] held;
  logic                     overrun;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: delayed raw samples, run lengths of disagreement, chord window by deadline.
  logic [3:0] mRawQ[$];
  logic [3:0] mLevel;
  int         mRun[4];
  bit         mGather, mPend, mOver;
  int         mEdge, mDeadline;
  logic [3:0] mMask;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CHORD_CYCLES    (CHORD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btnU        (btnU),
    .btnD        (btnD),
    .btnL        (btnL),
    .btnR        (btnR),
    .state       (state),
    .press_valid (press_valid),
    .press_arrow (press_arrow),
    .press_ready (press_ready),
    .held        (held),
    .overrun     (overrun)
  );

  task automatic model_reset();
    mRawQ.delete();
    for (int i = 0; i < DLY; i++) mRawQ.push_back(4'b0);
    mLevel = 4'b0;
    for (int b = 0; b < 4; b++) mRun[b] = 0;
    mGather = 0; mPend = 0; mOver = 0;
    mEdge = 0; mDeadline = 0;
    mMask = 4'b0;
  endtask

  task automatic model_edge();
    logic [3:0] smp, rise;
    if (reset) begin
      model_reset();
      return;
    end
    smp = mRawQ.pop_front();
    mRawQ.push_back({btnU, btnD, btnL, btnR});
    rise = 4'b0;
    for (int b = 0; b < 4; b++) begin
      if (smp[b] != mLevel[b]) begin
        mRun[b]++;
        if (mRun[b] == DEB) begin
          mLevel[b] = ~mLevel[b];
          mRun[b] = 0;
          if (mLevel[b]) rise[b] = 1'b1;
        end
      end else begin
        mRun[b] = 0;
      end
    end
    mEdge++;
    if (state != STATE_PLAY) begin
      mGather = 0; mPend = 0; mMask = 4'b0; mOver = 0;
    end else if (mPend) begin
      if (press_ready) begin
        mPend = 0;
        mMask = 4'b0;
        if (rise != 4'b0) begin
          mGather = 1; mDeadline = mEdge + CHORD; mMask = rise;
        end
      end else if (rise != 4'b0) begin
        mOver = 1;
      end
    end else if (mGather) begin
      mMask |= rise;
      if (mEdge == mDeadline) begin
        mGather = 0; mPend = 1;
      end
    end else if (rise != 4'b0) begin
      mGather = 1; mDeadline = mEdge + CHORD; mMask = rise;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_btn(input logic [3:0] v);
    {btnU, btnD, btnL, btnR} = v;
  endtask

  task automatic do_reset();
    set_btn(4'b0);
    press_ready = 1'b0;
    state = STATE_PLAY;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nCompared += 4;
    if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_valid: got %b expected 0", press_valid); end
    if (press_arrow !== 4'b0) begin nMismatched++; $display("FAIL reset_arrow: got %b expected 0000", press_arrow); end
    if (held !== 4'b0) begin nMismatched++; $display("FAIL reset_held: got %b expected 0000", held); end
    if (overrun !== 1'b0) begin nMismatched++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_single_press();
    do_reset();
    set_btn(4'b1000);
    for (int e = 0; e <= LAT; e++) begin
      tick();
      if (e == HE - 1) begin
        nCompared++;
        if (held !== 4'b0000) begin nMismatched++; $display("FAIL single_held_early: got %b expected 0000", held); end
      end
      if (e == HE) begin
        nCompared++;
        if (held !== 4'b1000) begin nMismatched++; $display("FAIL single_held: got %b expected 1000", held); end
      end
      if (e == LAT - 1) begin
        nCompared++;
        if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL single_valid_early: got %b expected 0", press_valid); end
      end
      if (e == LAT) begin
        nCompared += 2;
        if (press_valid !== 1'b1) begin nMismatched++; $display("FAIL single_valid: got %b expected 1", press_valid); end
        if (press_arrow !== 4'b1000) begin nMismatched++; $display("FAIL single_arrow: got %b expected 1000", press_arrow); end
      end
    end
  endtask

  task automatic test_chord();
    do_reset();
    set_btn(4'b0010);
    for (int e = 0; e <= LAT; e++) begin
      if (e == 2) set_btn(4'b0011);
      tick();
      if (e == LAT - 1) begin
        nCompared++;
        if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL chord_valid_early: got %b expected 0", press_valid); end
      end
      if (e == LAT) begin
        nCompared += 2;
        if (press_valid !== 1'b1) begin nMismatched++; $display("FAIL chord_valid: got %b expected 1", press_valid); end
        if (press_arrow !== 4'b0011) begin nMismatched++; $display("FAIL chord_arrow: got %b expected 0011", press_arrow); end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    set_btn(4'b0100);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) set_btn(4'b0000);
      tick();
      nCompared++;
      if (held !== 4'b0 || press_valid !== 1'b0) begin
        nMismatched++;
        $display("FAIL glitch_edge%0d: got held=%b valid=%b expected held=0000 valid=0", i, held, press_valid);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    set_btn(4'b1000);
    repeat (LAT + 1) tick();
    set_btn(4'b1001);
    repeat (HE + 2) tick();
    nCompared += 3;
    if (press_valid !== 1'b1) begin nMismatched++; $display("FAIL overrun_valid: got %b expected 1", press_valid); end
    if (overrun !== 1'b1) begin nMismatched++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    if (press_arrow !== 4'b1000) begin nMismatched++; $display("FAIL overrun_arrow: got %b expected 1000", press_arrow); end
    press_ready = 1'b1;
    tick();
    press_ready = 1'b0;
    nCompared += 2;
    if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL overrun_accept: got %b expected 0", press_valid); end
    if (overrun !== 1'b1) begin nMismatched++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_btn(4'b0010);
    repeat (LAT + 1) tick();
    nCompared++;
    if (press_valid !== 1'b1) begin nMismatched++; $display("FAIL b2b_first_valid: got %b expected 1", press_valid); end
    set_btn(4'b1010);
    for (int i = 0; i <= HE; i++) begin
      if (i == HE) press_ready = 1'b1;
      tick();
    end
    press_ready = 1'b0;
    nCompared += 2;
    if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL b2b_drop: got %b expected 0", press_valid); end
    if (overrun !== 1'b0) begin nMismatched++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    tick();
    tick();
    nCompared++;
    if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL b2b_early: got %b expected 0", press_valid); end
    tick();
    nCompared += 2;
    if (press_valid !== 1'b1) begin nMismatched++; $display("FAIL b2b_second_valid: got %b expected 1", press_valid); end
    if (press_arrow !== 4'b1000) begin nMismatched++; $display("FAIL b2b_second_arrow: got %b expected 1000", press_arrow); end
  endtask

  task automatic test_leave_play();
    do_reset();
    set_btn(4'b0001);
    repeat (LAT + 1) tick();
    set_btn(4'b0101);
    repeat (HE + 2) tick();
    nCompared++;
    if (overrun !== 1'b1) begin nMismatched++; $display("FAIL leave_pre_overrun: got %b expected 1", overrun); end
    state = NOPLAY;
    tick();
    nCompared += 3;
    if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL leave_valid: got %b expected 0", press_valid); end
    if (overrun !== 1'b0) begin nMismatched++; $display("FAIL leave_overrun: got %b expected 0", overrun); end
    if (held !== 4'b0101) begin nMismatched++; $display("FAIL leave_held: got %b expected 0101", held); end
    set_btn(4'b1101);
    repeat (HE + 2) tick();
    nCompared++;
    if (held !== 4'b1101) begin nMismatched++; $display("FAIL leave_held_live: got %b expected 1101", held); end
    state = STATE_PLAY;
    repeat (LAT + 2) tick();
    nCompared++;
    if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL leave_resume: got %b expected 0", press_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_btn(4'b1000);
    repeat (HE + 2) tick();
    #2;
    reset = 1'b1;
    #1;
    nCompared += 2;
    if (held !== 4'b0) begin nMismatched++; $display("FAIL resetmid_held: got %b expected 0000", held); end
    if (press_valid !== 1'b0 || press_arrow !== 4'b0 || overrun !== 1'b0) begin
      nMismatched++;
      $display("FAIL resetmid_outs: got valid=%b arrow=%b overrun=%b expected 0/0000/0", press_valid, press_arrow, overrun);
    end
    set_btn(4'b0);
    tick();
    reset = 1'b0;
    repeat (LAT + 2) tick();
    nCompared++;
    if (press_valid !== 1'b0) begin nMismatched++; $display("FAIL resetmid_discard: got %b expected 0", press_valid); end
  endtask

  task automatic test_random();
    logic [3:0] v;
    bit         play;
    do_reset();
    v = 4'b0;
    play = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) v ^= 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) play = !play;
      set_btn(v);
      press_ready = ($urandom_range(0, 3) == 0);
      state = play ? STATE_PLAY : NOPLAY;
      tick();
      nCompared++;
      if (press_valid !== mPend || press_arrow !== (mPend ? mMask : 4'b0) ||
          held !== mLevel || overrun !== mOver) begin
        nMismatched++;
        $display("FAIL random_cycle%0d: got valid=%b arrow=%b held=%b ovr=%b expected valid=%b arrow=%b held=%b ovr=%b",
                 c, press_valid, press_arrow, held, overrun, mPend, (mPend ? mMask : 4'b0), mLevel, mOver);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    set_btn(4'b0);
    press_ready = 1'b0;
    state = STATE_PLAY;
    model_reset();
    test_reset();
    test_single_press();
    test_chord();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_leave_play();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

`default_nettype wire
